// File: rtl/pwm_duty_capture_if.sv
// Result bus of the PWM duty capture block: one strobe plus the measured
// period, high time, recovered brightness code and status flags.
interface pwm_duty_capture_if #(
  parameter int PWM_BITS  = 8,
  parameter int CNT_WIDTH = 16
);
  logic [PWM_BITS-1:0]  duty;
  logic [CNT_WIDTH-1:0] high_time;
  logic [CNT_WIDTH-1:0] period;
  logic                 valid;
  logic                 period_err;
  logic                 stuck;

  // Producer side (the capture block)
  modport master (
    output duty, high_time, period, valid, period_err, stuck
  );

  // Consumer side (status / monitor logic)
  modport slave (
    input duty, high_time, period, valid, period_err, stuck
  );
endinterface

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of an asynchronous PWM line and recovers the
// brightness code. One result strobe per completed period; a line without a
// rising edge for TIMEOUT_CYCLES is reported as stuck at its current level.
module pwm_duty_capture #(
  parameter int PWM_BITS       = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  pwm_duty_capture_if.master   res
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_NOM = CNT_WIDTH'(2 ** PWM_BITS);
  localparam logic [PWM_BITS-1:0]  DUTY_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] DUTY_MAX_W = CNT_WIDTH'(2 ** PWM_BITS - 1);
  // Idle count value whose increment would reach TIMEOUT_CYCLES.
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_WAIT,
    S_MEASURE
  } state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_WIDTH-1:0] idle_q, idle_d;

  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic [CNT_WIDTH-1:0] high_time_q, high_time_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 period_err_q, period_err_d;
  logic                 stuck_q, stuck_d;

  logic rise;
  logic timeout_hit;
  logic [PWM_BITS-1:0] duty_sat;

  assign rise        = s2_q & ~s3_q;
  // A simultaneous rise takes priority over the timeout.
  assign timeout_hit = (idle_q == IDLE_LAST) & ~rise;
  assign duty_sat    = (high_cnt_q > DUTY_MAX_W) ? DUTY_MAX : high_cnt_q[PWM_BITS-1:0];

  // Next-state: counters, FSM transitions and result publication.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    high_time_d  = high_time_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    period_err_d = period_err_q;
    stuck_d      = stuck_q;

    if (rise) begin
      period_cnt_d = CNT_ONE;
      high_cnt_d   = CNT_ONE;
    end else begin
      period_cnt_d = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
      if (s2_q && high_cnt_q != CNT_MAX) begin
        high_cnt_d = high_cnt_q + CNT_ONE;
      end else begin
        high_cnt_d = high_cnt_q;
      end
    end

    if (rise || timeout_hit) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + CNT_ONE;
    end

    if (timeout_hit) begin
      valid_d      = 1'b1;
      stuck_d      = 1'b1;
      period_d     = '0;
      high_time_d  = '0;
      period_err_d = 1'b0;
      duty_d       = s2_q ? DUTY_MAX : '0;
      state_d      = S_WAIT;
    end

    case (state_q)
      S_WAIT: begin
        // The period before the first rise is partial, so nothing is published.
        if (rise) begin
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (rise) begin
          valid_d      = 1'b1;
          stuck_d      = 1'b0;
          period_d     = period_cnt_q;
          high_time_d  = high_cnt_q;
          period_err_d = (period_cnt_q != PERIOD_NOM);
          duty_d       = duty_sat;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State, synchronizer and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      idle_q       <= '0;
      duty_q       <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      period_err_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= pwm_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      idle_q       <= idle_d;
      duty_q       <= duty_d;
      high_time_q  <= high_time_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      period_err_q <= period_err_d;
      stuck_q      <= stuck_d;
    end
  end

  assign res.duty       = duty_q;
  assign res.high_time  = high_time_q;
  assign res.period     = period_q;
  assign res.valid      = valid_q;
  assign res.period_err = period_err_q;
  assign res.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Scoreboard bench for pwm_duty_capture: a reference model derives expected
// results from edge timestamps of the line, a monitor checks every strobe.
module tb_pwm_duty_capture;

  localparam int PWM_BITS  = 8;
  localparam int CNT_WIDTH = 16;
  localparam int TIMEOUT   = 4096;
  localparam int NOMINAL   = 1 << PWM_BITS;
  localparam int DMAX      = NOMINAL - 1;
  localparam int CMAX      = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwm_in = 1'b0;

  always #5 clk = ~clk;

  pwm_duty_capture_if #(.PWM_BITS(PWM_BITS), .CNT_WIDTH(CNT_WIDTH)) res_if ();

  pwm_duty_capture #(
    .PWM_BITS(PWM_BITS),
    .CNT_WIDTH(CNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .res(res_if)
  );

  typedef struct {
    int duty;
    int high;
    int period;
    int perr;
    int stuck;
  } res_t;

  res_t exp_q[$];
  res_t held;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  // Reference model state: timestamps in clock edges.
  int edge_n = 0;
  int rise_edge = 0;
  int clear_edge = 0;
  int hcnt = 0;
  bit measuring = 0;
  bit smp[3] = '{0, 0, 0};

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: level seen by the logic lags pwm_in by two sampling
  // edges; results come from rise timestamps and high-sample counts.
  always @(posedge clk) begin
    res_t r;
    bit cur, prv, rs;
    if (!rst_n) begin
      smp        = '{0, 0, 0};
      measuring  = 0;
      clear_edge = edge_n;
      held       = '{0, 0, 0, 0, 0};
      exp_q.delete();
      checking   = 1;
    end else begin
      cur = smp[1];
      prv = smp[2];
      rs  = cur && !prv;
      if (rs) begin
        if (measuring) begin
          r.period = min_i(edge_n - rise_edge, CMAX);
          r.high   = min_i(hcnt, CMAX);
          r.duty   = min_i(hcnt, DMAX);
          r.perr   = (r.period != NOMINAL) ? 1 : 0;
          r.stuck  = 0;
          exp_q.push_back(r);
          held = r;
        end
        measuring  = 1;
        rise_edge  = edge_n;
        hcnt       = 1;
        clear_edge = edge_n;
      end else begin
        if (cur) hcnt++;
        if (edge_n - clear_edge == TIMEOUT) begin
          r = '{cur ? DMAX : 0, 0, 0, 0, 1};
          exp_q.push_back(r);
          held       = r;
          measuring  = 0;
          clear_edge = edge_n;
        end
      end
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = pwm_in;
    end
    edge_n++;
  end

  // Monitor: pops an expected result on every strobe, checks held outputs.
  always @(negedge clk) begin
    res_t e;
    if (checking) begin
      if (res_if.valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("duty", int'(res_if.duty), e.duty);
          chk("high_time", int'(res_if.high_time), e.high);
          chk("period", int'(res_if.period), e.period);
          chk("period_err", int'(res_if.period_err), e.perr);
          chk("stuck", int'(res_if.stuck), e.stuck);
          $display("strobe duty=%0d high=%0d period=%0d err=%0d stuck=%0d",
                   res_if.duty, res_if.high_time, res_if.period,
                   res_if.period_err, res_if.stuck);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_valid", 0, 1);
        exp_q.delete();
      end
      chk("held_duty", int'(res_if.duty), held.duty);
      chk("held_period", int'(res_if.period), held.period);
      chk("held_high", int'(res_if.high_time), held.high);
      chk("held_flags", int'({res_if.period_err, res_if.stuck}),
          held.perr * 2 + held.stuck);
    end
  end

  task automatic drive(bit v, int n);
    repeat (n) begin
      pwm_in = v;
      @(negedge clk);
    end
  endtask

  task automatic periods(int hi, int lo, int cnt);
    repeat (cnt) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Nominal code 100, then the extremes 255 and 1
    periods(100, 156, 4);
    periods(255, 1, 3);
    periods(1, 255, 3);

    // Stuck low, stuck high, then resume
    drive(1'b0, 9000);
    drive(1'b1, 5000);
    periods(128, 128, 3);

    // Off-nominal periods, including duty saturation
    periods(50, 150, 3);
    periods(1000, 24, 3);

    // Minimum legal period
    periods(1, 1, 6);

    // One-cycle reset in the middle of a period
    periods(100, 156, 2);
    drive(1'b1, 100);
    drive(1'b0, 60);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 96);
    periods(100, 156, 3);

    // Fader-like ramp of codes
    for (int b = 1; b <= 40; b++) begin
      periods(b, NOMINAL - b, 1);
    end

    // Randomized periods with random phase
    drive(1'b0, $urandom_range(1, 20));
    for (int i = 0; i < 12; i++) begin
      periods($urandom_range(1, 300), $urandom_range(1, 300), 1);
    end
    for (int i = 0; i < 8; i++) begin
      int b;
      b = $urandom_range(1, 255);
      periods(b, NOMINAL - b, 1);
    end
    drive(1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
